// File: rtl/serial_fp_sum_frontend.sv
// Serial front/back end for the multi-operand FP adder.
// Captures one frame: a serial setup word, N_LANES serial operands, a fixed
// wait on the parallel sum unit, then a handshaked serial result.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for frame_start_in; no data sampled
// S_SETUP | shifting SETUP_W setup bits (lane mask + subtract flags)
// S_LOAD  | shifting WIDTH bits into each enabled lane
// S_WAIT  | operands valid, counting RESULT_LATENCY edges for the sum
// S_OUT   | result shifted out MSB first, one bit per output_read_in edge
module serial_fp_sum_frontend #(
  parameter int N_LANES        = 4,
  parameter int WIDTH          = 16,
  parameter int RESULT_LATENCY = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       frame_start_in,
  input  logic                       setup_serial_in,
  input  logic [N_LANES-1:0]         serial_in,
  output logic                       input_rdy,
  output logic [N_LANES*WIDTH-1:0]   operands_out,
  output logic [N_LANES-1:0]         lane_mask_out,
  output logic [N_LANES-2:0]         sub_op_out,
  input  logic [WIDTH-1:0]           result_in,
  output logic                       output_rdy,
  input  logic                       output_read_in,
  output logic                       serial_out,
  output logic                       overrun
);

  localparam int SETUP_W = 2*N_LANES-1;
  localparam int MAX_A   = (SETUP_W > WIDTH) ? SETUP_W : WIDTH;
  localparam int CNT_MAX = (MAX_A > RESULT_LATENCY) ? MAX_A : RESULT_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SETUP_W-1:0]         setup_q, setup_d;
  logic [N_LANES*WIDTH-1:0]   lanes_q, lanes_d;
  logic [WIDTH-1:0]           res_q, res_d;
  logic                       overrun_q, overrun_d;

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      setup_q   <= '0;
      lanes_q   <= '0;
      res_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      setup_q   <= setup_d;
      lanes_q   <= lanes_d;
      res_q     <= res_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic; cnt_q is a down-counter reloaded on every phase change
  // and the phase ends on the edge where it reads zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    setup_d   = setup_q;
    lanes_d   = lanes_q;
    res_d     = res_q;
    overrun_d = overrun_q;

    // A start strobe in the cycle that finishes OUT is still a busy start.
    if (frame_start_in && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          state_d   = S_SETUP;
          cnt_d     = CNT_W'(SETUP_W-1);
          setup_d   = '0;
          lanes_d   = '0;
          overrun_d = 1'b0;
        end
      end
      S_SETUP: begin
        setup_d = {setup_q[SETUP_W-2:0], setup_serial_in};
        if (cnt_q == '0) begin
          state_d = S_LOAD;
          cnt_d   = CNT_W'(WIDTH-1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOAD: begin
        for (int k = 0; k < N_LANES; k++) begin
          if (setup_q[k]) begin
            lanes_d[k*WIDTH +: WIDTH] = {lanes_q[k*WIDTH +: WIDTH-1], serial_in[k]};
          end else begin
            lanes_d[k*WIDTH +: WIDTH] = '0;
          end
        end
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RESULT_LATENCY-1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_OUT;
          res_d   = result_in;
          cnt_d   = CNT_W'(WIDTH-1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OUT: begin
        if (output_read_in) begin
          res_d = {res_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign input_rdy     = (state_q == S_IDLE);
  assign output_rdy    = (state_q == S_OUT);
  assign serial_out    = output_rdy & res_q[WIDTH-1];
  assign operands_out  = lanes_q;
  assign lane_mask_out = setup_q[N_LANES-1:0];
  assign sub_op_out    = setup_q[SETUP_W-1:N_LANES];
  assign overrun       = overrun_q;

endmodule
